// File: rtl/pipelined_ripple_addsub_if.sv
// Operand/result bus of the pipelined ripple adder/subtractor.
// The operand side and the result side each carry a valid/ready pair.
interface pipelined_ripple_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_ripple_addsub.sv
// Pipelined ripple-carry adder/subtractor: WIDTH bits split into STAGES chunks,
// one chunk rippled per register stage, whole pipe freezes while the result is stalled.
module pipelined_ripple_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    pipelined_ripple_addsub_if.slave bus
);
    localparam int C = WIDTH / STAGES;

    logic stall;
    logic accept;

    assign stall        = g_stg[STAGES-1].vld_q && !bus.out_ready;
    assign bus.in_ready = rst || !stall;
    assign accept       = bus.in_valid && !stall;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int LO = k * C;
        localparam int HI = LO + C;

        logic [WIDTH-LO-1:0] a_in;
        logic [WIDTH-LO-1:0] b_in;
        logic                c_in;
        logic                v_in;
        logic [C-1:0]        s_chunk;
        logic [C:0]          cy;
        logic [HI-1:0]       sum_d;
        logic [HI-1:0]       sum_q;
        logic                cry_q;
        logic                vld_q;

        // Subtraction is folded in at the entry: a + ~b + ~cin.
        if (k == 0) begin : g_src
            assign a_in = bus.a;
            assign b_in = bus.b ^ {WIDTH{bus.sub}};
            assign c_in = bus.cin ^ bus.sub;
            assign v_in = accept;
        end else begin : g_src
            assign a_in = g_stg[k-1].g_rem.ra_q;
            assign b_in = g_stg[k-1].g_rem.rb_q;
            assign c_in = g_stg[k-1].cry_q;
            assign v_in = g_stg[k-1].vld_q;
        end

        always_comb begin
            s_chunk = '0;
            cy      = '0;
            cy[0]   = c_in;
            for (int i = 0; i < C; i++) begin
                s_chunk[i] = a_in[i] ^ b_in[i] ^ cy[i];
                cy[i+1]    = (a_in[i] & b_in[i]) | (a_in[i] & cy[i]) | (b_in[i] & cy[i]);
            end
        end

        if (k == 0) begin : g_sum
            assign sum_d = s_chunk;
        end else begin : g_sum
            assign sum_d = {s_chunk, g_stg[k-1].sum_q};
        end

        // Data registers only load with a real op so outputs hold across bubbles.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= 1'b0;
                sum_q <= '0;
                cry_q <= 1'b0;
            end else if (!stall) begin
                vld_q <= v_in;
                if (v_in) begin
                    sum_q <= sum_d;
                    cry_q <= cy[C];
                end
            end
        end

        if (k < STAGES - 1) begin : g_rem
            logic [WIDTH-HI-1:0] ra_q;
            logic [WIDTH-HI-1:0] rb_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    ra_q <= '0;
                    rb_q <= '0;
                end else if (!stall && v_in) begin
                    ra_q <= a_in[WIDTH-LO-1:C];
                    rb_q <= b_in[WIDTH-LO-1:C];
                end
            end
        end

        if (k == STAGES - 1) begin : g_last
            logic ovf_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (!stall && v_in) begin
                    ovf_q <= cy[C-1] ^ cy[C];
                end
            end
        end
    end

    assign bus.out_valid = g_stg[STAGES-1].vld_q;
    assign bus.sum       = g_stg[STAGES-1].sum_q;
    assign bus.cout      = g_stg[STAGES-1].cry_q;
    assign bus.ovf       = g_stg[STAGES-1].g_last.ovf_q;
endmodule
